reset_ctrl: RTL and testbench

RESET_CTRL -- requirements
Module: reset_ctrl

---
 rtl/reset_ctrl_pkg.sv | 25 ++
 rtl/reset_ctrl_timer.sv | 34 +++
 rtl/reset_ctrl.sv | 177 +++++++++++++++++
 tb/tb_reset_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encoding and a small helper.
// The cause type is used only when RESET_CTRL_CAUSE_EN is defined.
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StHold    = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } state_e;

    localparam int unsigned CauseW = 2;

    typedef enum logic [CauseW-1:0] {
        CausePor = 2'd0,
        CauseExt = 2'd1,
        CauseDbg = 2'd2,
        CauseSw  = 2'd3
    } cause_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_ctrl_timer.sv
// Loadable saturating down-counter with a zero flag; shared by the HOLD and RELEASE phases.
module reset_ctrl_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_ctrl.sv
// Sequenced reset controller: holds all domains in reset, then releases them one by one.
// Define RESET_CTRL_CAUSE_EN to add the registered rst_cause output.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int unsigned Domains    = 3,
    parameter int unsigned HoldCycles = 16,
    parameter int unsigned StageGap   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ext_rst_req,
    input  logic               ndmreset,
    input  logic               sw_rst_req,
    input  logic               havereset_ack,
    output logic [Domains-1:0] dom_rst_n,
    output logic               rst_done,
`ifdef RESET_CTRL_CAUSE_EN
    output logic [CauseW-1:0]  rst_cause,
`endif
    output logic               havereset
);

    localparam int unsigned CntW = $clog2(max_u(HoldCycles, StageGap) + 1);
    localparam int unsigned IdxW = (Domains > 1) ? $clog2(Domains) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(StageGap - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(Domains - 1);

    state_e             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               sw_q, sw_d;
    logic [Domains-1:0] dom_q, dom_d;
    logic               done_q, done_d;
    logic               have_q, have_d;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [CntW-1:0]    tmr_val;
    logic               req_any;

    // A pulse landing in ASSERT is remembered so it counts in the first HOLD cycle.
    assign sw_d    = sw_rst_req & (state_q == StAssert);
    assign req_any = ext_rst_req | ndmreset | sw_rst_req | sw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAssert;
            idx_q   <= '0;
            sw_q    <= 1'b0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            have_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sw_q    <= sw_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            have_q  <= have_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = HoldLoad;
        tmr_dec  = 1'b0;
        case (state_q)
            StAssert: begin
                state_d  = StHold;
                idx_d    = '0;
                tmr_load = 1'b1;
            end
            StHold: begin
                if (req_any) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = StRelease;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = GapLoad;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StRelease: begin
                // The last domain moves straight to RUN without a stage gap.
                if (req_any) begin
                    state_d = StAssert;
                end else if (idx_q == LastIdx) begin
                    state_d = StRun;
                end else if (tmr_zero) begin
                    idx_d    = idx_q + 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GapLoad;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StRun: begin
                if (req_any) begin
                    state_d = StAssert;
                end
            end
            default: state_d = StAssert;
        endcase
    end

    always_comb begin
        dom_d  = '0;
        done_d = 1'b0;
        have_d = have_q;
        case (state_d)
            StRelease: begin
                dom_d = dom_q;
                for (int i = 0; i < Domains; i++) begin
                    if (idx_d == IdxW'(i)) begin
                        dom_d[i] = 1'b1;
                    end
                end
            end
            StRun: begin
                dom_d  = '1;
                done_d = 1'b1;
            end
            default: ;
        endcase
        if (state_d == StAssert) begin
            have_d = 1'b1;
        end else if ((state_q == StRun) && havereset_ack) begin
            have_d = 1'b0;
        end
    end

    reset_ctrl_timer #(
        .Width(CntW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

`ifdef RESET_CTRL_CAUSE_EN
    cause_e cause_q, cause_d;

    always_comb begin
        cause_d = cause_q;
        if ((state_d == StAssert) && (state_q != StAssert)) begin
            if (ext_rst_req) begin
                cause_d = CauseExt;
            end else if (ndmreset) begin
                cause_d = CauseDbg;
            end else begin
                cause_d = CauseSw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= CausePor;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign rst_cause = cause_q;
`endif

    assign dom_rst_n = dom_q;
    assign rst_done  = done_q;
    assign havereset = have_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl (Domains=3, HoldCycles=4, StageGap=2); cycle N is the
// interval after clock edge N, edge 0 being the last edge with rst high.
module tb_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst, ext_rst_req, ndmreset, sw_rst_req, havereset_ack;
    logic [2:0] dom_rst_n;
    logic       rst_done, havereset;
`ifdef RESET_CTRL_CAUSE_EN
    logic [1:0] rst_cause;
`endif

    int cyc = -1;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        string      name;
        bit         is_cause;
        logic [2:0] dom;
        logic       done;
        logic       have;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];

    reset_ctrl #(
        .Domains   (3),
        .HoldCycles(4),
        .StageGap  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_rst_req  (ext_rst_req),
        .ndmreset     (ndmreset),
        .sw_rst_req   (sw_rst_req),
        .havereset_ack(havereset_ack),
        .dom_rst_n    (dom_rst_n),
        .rst_done     (rst_done),
`ifdef RESET_CTRL_CAUSE_EN
        .rst_cause    (rst_cause),
`endif
        .havereset    (havereset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_out(input int c, input string nm, input logic [2:0] d, input logic dn,
                           input logic hv);
        exp_t e;
        e.cyc = c; e.name = nm; e.is_cause = 1'b0;
        e.dom = d; e.done = dn; e.have = hv; e.cause = 2'd0;
        sb.push_back(e);
    endtask

    task automatic exp_cause(input int c, input string nm, input logic [1:0] cs);
`ifdef RESET_CTRL_CAUSE_EN
        exp_t e;
        e.cyc = c; e.name = nm; e.is_cause = 1'b1;
        e.dom = '0; e.done = 1'b0; e.have = 1'b0; e.cause = cs;
        sb.push_back(e);
`else
        if (c < 0 || nm.len() < 0 || cs > 2'd3) $display("bad exp_cause args");
`endif
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops every expectation due this cycle and compares on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (e.is_cause) begin
`ifdef RESET_CTRL_CAUSE_EN
                if (rst_cause !== e.cause) begin
                    n_fail++;
                    $display("FAIL %s @%0d: rst_cause=%0d want %0d", e.name, cyc, rst_cause,
                             e.cause);
                end
`endif
            end else if (dom_rst_n !== e.dom || rst_done !== e.done || havereset !== e.have) begin
                n_fail++;
                $display("FAIL %s @%0d: dom=%b done=%b have=%b want dom=%b done=%b have=%b",
                         e.name, cyc, dom_rst_n, rst_done, havereset, e.dom, e.done, e.have);
            end
        end
    end

    initial begin
        rst = 1'b1; ext_rst_req = 1'b0; ndmreset = 1'b0; sw_rst_req = 1'b0;
        havereset_ack = 1'b0;

        // Power-on sequence with an ack during HOLD that must be ignored.
        exp_cause(0, "por_cause", 2'd0);
        for (int c = 0; c <= 4; c++) exp_out(c, "por_hold", 3'b000, 1'b0, 1'b1);
        exp_out(5, "por_dom0", 3'b001, 1'b0, 1'b1);
        exp_out(6, "por_dom0_b", 3'b001, 1'b0, 1'b1);
        exp_out(7, "por_dom1", 3'b011, 1'b0, 1'b1);
        exp_out(8, "por_dom1_b", 3'b011, 1'b0, 1'b1);
        exp_out(9, "por_dom2", 3'b111, 1'b0, 1'b1);
        exp_out(10, "por_done", 3'b111, 1'b1, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        at_cycle(2);  havereset_ack = 1'b1;
        at_cycle(3);  havereset_ack = 1'b0;

        // Ack in RUN clears havereset.
        exp_out(12, "ack_run_pre", 3'b111, 1'b1, 1'b1);
        exp_out(13, "ack_run_clr", 3'b111, 1'b1, 1'b0);
        at_cycle(12); havereset_ack = 1'b1;
        at_cycle(13); havereset_ack = 1'b0;

        // Debug reset held for 10 cycles.
        exp_out(15, "ndm_pre", 3'b111, 1'b1, 1'b0);
        exp_out(16, "ndm_drop", 3'b000, 1'b0, 1'b1);
        exp_cause(16, "ndm_cause", 2'd2);
        exp_out(24, "ndm_held", 3'b000, 1'b0, 1'b1);
        exp_out(28, "ndm_hold_end", 3'b000, 1'b0, 1'b1);
        exp_out(29, "ndm_dom0", 3'b001, 1'b0, 1'b1);
        exp_out(31, "ndm_dom1", 3'b011, 1'b0, 1'b1);
        exp_out(33, "ndm_dom2", 3'b111, 1'b0, 1'b1);
        exp_out(34, "ndm_done", 3'b111, 1'b1, 1'b1);
        at_cycle(15); ndmreset = 1'b1;
        at_cycle(25); ndmreset = 1'b0;

        // Ack together with an external request: set wins.
        exp_out(37, "ack_clr2", 3'b111, 1'b1, 1'b0);
        exp_out(40, "ext_pre", 3'b111, 1'b1, 1'b0);
        exp_out(41, "ext_ack_set_wins", 3'b000, 1'b0, 1'b1);
        exp_cause(41, "ext_cause", 2'd1);
        exp_out(45, "ext_hold_end", 3'b000, 1'b0, 1'b1);
        exp_out(46, "ext_dom0", 3'b001, 1'b0, 1'b1);
        exp_out(51, "ext_done", 3'b111, 1'b1, 1'b1);
        at_cycle(36); havereset_ack = 1'b1;
        at_cycle(37); havereset_ack = 1'b0;
        at_cycle(40); ext_rst_req = 1'b1; havereset_ack = 1'b1;
        at_cycle(41); ext_rst_req = 1'b0; havereset_ack = 1'b0;

        // rst mid-RUN, then a software pulse six cycles in restarts the sequence.
        exp_out(55, "rst_pre", 3'b111, 1'b1, 1'b1);
        exp_out(56, "rst_drop", 3'b000, 1'b0, 1'b1);
        exp_cause(56, "rst_cause_por", 2'd0);
        exp_out(61, "rst_dom0", 3'b001, 1'b0, 1'b1);
        exp_out(62, "sw_pre", 3'b001, 1'b0, 1'b1);
        exp_out(63, "sw_drop", 3'b000, 1'b0, 1'b1);
        exp_cause(63, "sw_cause", 2'd3);
        exp_out(67, "sw_hold_end", 3'b000, 1'b0, 1'b1);
        exp_out(68, "sw_dom0", 3'b001, 1'b0, 1'b1);
        exp_out(72, "sw_dom2", 3'b111, 1'b0, 1'b1);
        exp_out(73, "sw_done", 3'b111, 1'b1, 1'b1);
        at_cycle(55); rst = 1'b1;
        at_cycle(56); rst = 1'b0;
        at_cycle(62); sw_rst_req = 1'b1;
        at_cycle(63); sw_rst_req = 1'b0;

        // ext+sw together picks EXT; a sw pulse in HOLD restarts the count.
        exp_out(77, "extsw_drop", 3'b000, 1'b0, 1'b1);
        exp_cause(77, "extsw_cause", 2'd1);
        exp_out(83, "hold_restart", 3'b000, 1'b0, 1'b1);
        exp_out(84, "hold_restart_dom0", 3'b001, 1'b0, 1'b1);
        exp_out(89, "hold_restart_done", 3'b111, 1'b1, 1'b1);
        at_cycle(76); ext_rst_req = 1'b1; sw_rst_req = 1'b1;
        at_cycle(77); ext_rst_req = 1'b0; sw_rst_req = 1'b0;
        at_cycle(79); sw_rst_req = 1'b1;
        at_cycle(80); sw_rst_req = 1'b0;

        // rst, then a sw pulse during ASSERT delays release by one cycle.
        exp_out(91, "rst2_drop", 3'b000, 1'b0, 1'b1);
        exp_cause(91, "rst2_cause", 2'd0);
        exp_out(96, "assert_pulse_hold", 3'b000, 1'b0, 1'b1);
        exp_out(97, "assert_pulse_dom0", 3'b001, 1'b0, 1'b1);
        exp_cause(97, "assert_pulse_cause", 2'd0);
        at_cycle(90); rst = 1'b1;
        at_cycle(91); rst = 1'b0; sw_rst_req = 1'b1;
        at_cycle(92); sw_rst_req = 1'b0;

        at_cycle(100);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
